// File: rtl/clk_phase_checker.sv
// clk_phase_checker: verifies clk_2f/clk_f frequency and phase on clk_8f, reports lock and errors
module clk_phase_checker #(
  parameter int LOCK_PERIODS = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk_8f,
  input  logic             rst,
  input  logic             enb,
  input  logic             clk_2f,
  input  logic             clk_f,
  input  logic             clr_err,
  output logic             locked,
  output logic [2:0]       phase,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t r_state;
  logic r_s2, r_sf, r_p2, r_pf;
  logic [3:0] r_good;
  logic w_det, w_bad, w_max;
  // expected pattern: clk_2f high at phases 0,1,4,5; clk_f high at phases 0..3
  assign w_det = r_sf & ~r_pf & r_s2 & ~r_p2;
  assign w_bad = (r_s2 != ~phase[1]) | (r_sf != ~phase[2]);
  assign w_max = &err_cnt;
  always_ff @(posedge clk_8f or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
      r_s2 <= 1'b0;
      r_sf <= 1'b0;
      r_p2 <= 1'b0;
      r_pf <= 1'b0;
      r_good <= '0;
      phase <= '0;
      locked <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
    end else begin
      r_s2 <= clk_2f;
      r_sf <= clk_f;
      r_p2 <= r_s2;
      r_pf <= r_sf;
      err <= 1'b0;
      if (!enb) begin
        r_state <= HUNT;
        r_good <= '0;
        phase <= '0;
        locked <= 1'b0;
      end else begin
        case (r_state)
          HUNT: if (w_det) begin
            r_state <= CHECK;
            phase <= 3'd1;
            r_good <= '0;
          end
          default: if (w_bad) begin
            r_state <= HUNT;
            r_good <= '0;
            phase <= '0;
            locked <= 1'b0;
            if (r_state == LOCKED) begin
              err <= 1'b1;
              if (!w_max) err_cnt <= err_cnt + ERR_W'(1);
            end
          end else begin
            phase <= phase + 3'd1;
            if (r_state == CHECK && phase == 3'd7) begin
              r_good <= r_good + 4'd1;
              if (r_good + 4'd1 == 4'(LOCK_PERIODS)) begin
                r_state <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
        endcase
        if (clr_err) err_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_clk_phase_checker.sv
// tb_clk_phase_checker: directed checks of lock, phase tracking, error counting, enable and reset
module tb_clk_phase_checker;
  logic clk_8f = 1'b0;
  logic rst = 1'b1, enb = 1'b0, clk_2f = 1'b0, clk_f = 1'b0, clr_err = 1'b0;
  logic locked, err, locked2, err2;
  logic [2:0] phase, phase2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [2:0] g = 3'd0, gl = 3'd0;
  int h = 0;
  bit flip = 1'b0, mode10 = 1'b0;
  int n_asr = 0, n_fail = 0;

  clk_phase_checker dut (.clk_8f(clk_8f), .rst(rst), .enb(enb), .clk_2f(clk_2f), .clk_f(clk_f),
    .clr_err(clr_err), .locked(locked), .phase(phase), .err(err), .err_cnt(err_cnt));
  clk_phase_checker #(.ERR_W(2)) dut2 (.clk_8f(clk_8f), .rst(rst), .enb(enb), .clk_2f(clk_2f),
    .clk_f(clk_f), .clr_err(clr_err), .locked(locked2), .phase(phase2), .err(err2), .err_cnt(err_cnt2));

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clk_8f cycle of a generator model; outputs are observed 1 time unit after the edge
  task automatic cyc();
    @(negedge clk_8f);
    gl = g;
    clk_2f = ~g[1] ^ flip;
    clk_f = mode10 ? (h < 5) : ~g[2];
    g = g + 3'd1;
    h = (h + 1) % 10;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic relock();
    enb = 1'b0;
    cyc();
    for (int i = 0; i < 8 && gl != 3'd7; i++) cyc();
    enb = 1'b1;
    cyc();
    chk("relock_det_unlocked", 32'(locked), 0);
    repeat (15) cyc();
    chk("relock_15_unlocked", 32'(locked), 0);
    chk("relock_15_phase", 32'(phase), 7);
    cyc();
    chk("relock_16_locked", 32'(locked), 1);
    chk("relock_16_phase", 32'(phase), 0);
    chk("relock_16_locked_w2", 32'(locked2), 1);
  endtask

  task automatic inject(input bit clr, input int e1, input int e2);
    for (int i = 0; i < 8 && gl != 3'd1; i++) cyc();
    flip = 1'b1;
    cyc();
    flip = 1'b0;
    chk("inj_x_locked", 32'(locked), 1);
    clr_err = clr;
    cyc();
    clr_err = 1'b0;
    chk("inj_err", 32'(err), 1);
    chk("inj_err_w2", 32'(err2), 1);
    chk("inj_unlocked", 32'(locked), 0);
    chk("inj_phase", 32'(phase), 0);
    chk("inj_cnt", 32'(err_cnt), 32'(e1));
    chk("inj_cnt_w2", 32'(err_cnt2), 32'(e2));
    cyc();
    chk("inj_err_one_cycle", 32'(err), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk_8f);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    rst = 1'b0;
    relock();
    for (int i = 0; i < 200; i++) begin
      cyc();
      chk("run_phase", 32'(phase), 32'(gl));
      chk("run_locked", 32'(locked), 1);
      chk("run_err", 32'(err), 0);
      chk("run_cnt", 32'(err_cnt), 0);
    end
    inject(1'b0, 1, 1);
    repeat (4) cyc();
    chk("b_det_unlocked", 32'(locked), 0);
    repeat (15) cyc();
    chk("b_15_unlocked", 32'(locked), 0);
    cyc();
    chk("b_16_locked", 32'(locked), 1);
    enb = 1'b0;
    cyc();
    enb = 1'b1;
    mode10 = 1'b1;
    h = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      chk("f10_locked", 32'(locked), 0);
      chk("f10_err", 32'(err), 0);
      chk("f10_cnt", 32'(err_cnt), 1);
    end
    mode10 = 1'b0;
    relock();
    enb = 1'b0;
    repeat (5) begin
      cyc();
      chk("enb0_locked", 32'(locked), 0);
      chk("enb0_phase", 32'(phase), 0);
      chk("enb0_err", 32'(err), 0);
      chk("enb0_cnt", 32'(err_cnt), 1);
    end
    relock();
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("clr_cnt", 32'(err_cnt), 0);
    chk("clr_cnt_w2", 32'(err_cnt2), 0);
    chk("clr_keeps_lock", 32'(locked), 1);
    for (int k = 1; k <= 5; k++) begin
      inject(1'b0, k, (k > 3) ? 3 : k);
      relock();
    end
    inject(1'b1, 0, 0);
    relock();
    inject(1'b0, 1, 1);
    relock();
    for (int i = 0; i < 8 && gl != 3'd5; i++) cyc();
    chk("pre_rst_phase", 32'(phase), 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_locked", 32'(locked), 0);
    chk("arst_phase", 32'(phase), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_cnt", 32'(err_cnt), 0);
    chk("arst_cnt_w2", 32'(err_cnt2), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_phase_checker.md
# clk_phase_checker

Monitor running on `clk_8f` that samples the `clk_2f`/`clk_f` pair produced by the clock generator and checks their frequency and phase. It hunts for the common rising edge of both divided clocks and tracks the 8-cycle `clk_f` frame. It declares lock after a programmable number of clean frames and flags and counts every deviation. It sits beside the generator and gates downstream striping/unstriping logic on `locked`.

## Interface
- `LOCK_PERIODS`, 2: consecutive clean `clk_f` periods required for lock; legal range 1..15.
- `ERR_W`, 8: width of the saturating error counter.
- `clk_8f`  in  1  fast reference clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enb`  in  1  checker enable; same meaning as the generator enable.
- `clk_2f`  in  1  divided clock under test; expected period 4 `clk_8f` cycles.
- `clk_f`  in  1  divided clock under test; expected period 8 `clk_8f` cycles.
- `clr_err`  in  1  synchronous clear of `err_cnt`.
- `locked`  out  1  frame lock indication.
- `phase`  out  3  current position in the `clk_f` frame; 0 when not tracking.
- `err`  out  1  one-cycle pulse per detected mismatch.
- `err_cnt`  out  ERR_W  saturating count of mismatches.

## Operation
- Input stage: `s2`/`sf` register `clk_2f`/`clk_f`. `p2`/`pf` register `s2`/`sf`. All comparisons use `s2`/`sf`.
- Expected pattern, indexed by phase 0..7:
  - `s2` = 1,1,0,0,1,1,0,0
  - `sf` = 1,1,1,1,0,0,0,0
- States: HUNT, CHECK, LOCKED. A 4-bit `good_cnt` counts clean periods.
- HUNT:
  - Detection cycle: `sf & ~pf & s2 & ~p2`. This cycle is phase 0.
  - On detection, next state is CHECK, `phase` becomes 1, `good_cnt` becomes 0.
  - A `clk_f` rise without a coincident `clk_2f` rise is ignored. No error is raised in HUNT.
- CHECK and LOCKED:
  - `phase` increments mod 8 every cycle.
  - Each cycle, `s2`/`sf` are compared against the expected pattern at the current phase.
- CHECK, clean phase-7 cycle: `good_cnt` increments. When it reaches `LOCK_PERIODS`, next state is LOCKED.
- CHECK, mismatch: return to HUNT. `err` and `err_cnt` are not affected (not yet locked).
- LOCKED, mismatch: next state HUNT, `err` pulses, `err_cnt` increments (saturates at 2^ERR_W-1).
- `enb`=0 (synchronous, overrides everything except `rst`):
  - State goes to HUNT; `phase`, `good_cnt` and `locked` go to 0.
  - No `err` is raised; `err_cnt` holds.
  - The input stage keeps sampling.
- `clr_err`: `err_cnt` goes to 0 next cycle. If a simultaneous increment occurs, the clear wins (result 0), but `err` still pulses.
- `locked` is a registered output: it equals 1 iff state is LOCKED.

## Timing
- Reset (async): state HUNT; `s2`, `sf`, `p2`, `pf`, `phase`, `good_cnt`, `locked`, `err`, `err_cnt` all 0.
- Input latency: 1 cycle from a `clk_2f`/`clk_f` change to `s2`/`sf`.
- Lock latency: `locked` rises 8*LOCK_PERIODS cycles after the detection cycle. With default 2, that is 16 cycles.
- Error latency: a mismatch on `s2`/`sf` in cycle X gives `err`=1 and the `err_cnt` update in cycle X+1, with `locked`=0 in X+1.
- Earliest re-detection: cycle X+1. `locked` then needs another 8*LOCK_PERIODS cycles.
- Boundary cases:
  - Mismatch at phase 7 of the final locking period: no lock, back to HUNT.
  - `err_cnt` at saturation: holds at maximum and `err` still pulses.
  - `rst` mid-frame: immediate return to reset values regardless of state.

## Test plan
- Clean generator, `enb`=1 after reset, `LOCK_PERIODS`=2 -> `locked`=1 exactly 16 cycles after detection. `phase` then cycles 0..7 with `phase`=0 on each `s2`/`sf` common rise. `err`=0 and `err_cnt`=0 for 200 cycles.
- Locked, then force `clk_2f` high for one extra cycle at phase 2 -> `err` pulses 1 cycle, `err_cnt`=1, `locked`=0. Relock 16 cycles after the next detection.
- Feed `clk_f` with an 10-cycle period -> never locks; `err_cnt` stays 0.
- Locked, then `enb`=0 for 5 cycles -> `locked`=0 and `phase`=0 next cycle; no `err`; `err_cnt` unchanged. Relocks after `enb` returns.
- `ERR_W`=2, inject 5 locked-state errors -> `err_cnt` saturates at 3 and `err` pulses 5 times. `clr_err` together with a sixth error -> `err_cnt`=0, `err`=1.
- Assert `rst` at phase 5 while locked -> all outputs 0 immediately, without waiting for a clock edge.
